// File: rtl/spi_slave_responder.sv
// SPI mode-0 responder. SCLK, SS_n and MOSI are oversampled in the clk domain.
// Words move MSB-first, and a single holding register feeds the tx shifter.
module spi_slave_responder #(
  parameter int                DATA_W      = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_TX     = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_ss_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_active,
  output logic              tx_underrun
);

  localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, ss_prev_q;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise_s, sclk_fall_s, ss_rise_s, ss_fall_s;
  logic                   word_load_s;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_tx_q, shift_tx_d;
  logic [DATA_W-1:0]   shift_rx_q, shift_rx_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                boundary_q, boundary_d;
  logic                tx_ready_q, tx_ready_d;
  logic                rx_valid_q, rx_valid_d;
  logic                underrun_q, underrun_d;
  logic                oe_q, oe_d;
  logic                frame_q, frame_d;
  logic                miso_q, miso_d;

  // Input synchronizers plus one delay stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s        = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_prev_q;
  assign sclk_fall_s = ~sclk_s & sclk_prev_q;
  assign ss_rise_s   = ss_s & ~ss_prev_q;
  assign ss_fall_s   = ~ss_s & ss_prev_q;

  // A deselect in the same clk as an SCLK edge suppresses the boundary reload.
  assign word_load_s = ((state_q == ST_IDLE) && ss_fall_s) ||
                       ((state_q == ST_ACTIVE) && !ss_rise_s && sclk_fall_s && boundary_q);

  // Next-state logic for the frame FSM, both shifters and the tx holding register.
  always_comb begin
    state_d    = state_q;
    shift_tx_d = shift_tx_q;
    shift_rx_d = shift_rx_q;
    hold_d     = hold_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    boundary_d = boundary_q;
    tx_ready_d = tx_ready_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    oe_d       = oe_q;
    frame_d    = frame_q;

    case (state_q)
      ST_IDLE: begin
        if (ss_fall_s) begin
          state_d    = ST_ACTIVE;
          oe_d       = 1'b1;
          frame_d    = 1'b1;
          bit_cnt_d  = '0;
          boundary_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (ss_rise_s) begin
          state_d    = ST_IDLE;
          oe_d       = 1'b0;
          frame_d    = 1'b0;
          bit_cnt_d  = '0;
          boundary_d = 1'b0;
        end else if (sclk_rise_s) begin
          shift_rx_d = {shift_rx_q[DATA_W-2:0], mosi_s};
          if (bit_cnt_q == LAST_CNT) begin
            rx_data_d  = {shift_rx_q[DATA_W-2:0], mosi_s};
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            boundary_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall_s) begin
          if (boundary_q) begin
            boundary_d = 1'b0;
          end else begin
            shift_tx_d = {shift_tx_q[DATA_W-2:0], 1'b0};
          end
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        oe_d    = 1'b0;
        frame_d = 1'b0;
      end
    endcase

    // Transfer needs a full register and capture an empty one, so they never overlap.
    if (word_load_s && !tx_ready_q) begin
      shift_tx_d = hold_q;
      tx_ready_d = 1'b1;
    end else if (word_load_s) begin
      shift_tx_d = IDLE_TX;
      underrun_d = 1'b1;
    end else begin
      underrun_d = 1'b0;
    end

    if (tx_valid && tx_ready_q) begin
      hold_d     = tx_data;
      tx_ready_d = 1'b0;
    end else begin
      hold_d = hold_q;
    end

    miso_d = oe_d & shift_tx_d[DATA_W-1];
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_tx_q <= '0;
      shift_rx_q <= '0;
      hold_q     <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      boundary_q <= 1'b0;
      tx_ready_q <= 1'b1;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      oe_q       <= 1'b0;
      frame_q    <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_tx_q <= shift_tx_d;
      shift_rx_q <= shift_rx_d;
      hold_q     <= hold_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      boundary_q <= boundary_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
      oe_q       <= oe_d;
      frame_q    <= frame_d;
      miso_q     <= miso_d;
    end
  end

  assign spi_miso     = miso_q;
  assign spi_miso_oe  = oe_q;
  assign tx_ready     = tx_ready_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign frame_active = frame_q;
  assign tx_underrun  = underrun_q;

endmodule
